// File: rtl/median_out_fifo.sv
// rtl/median_out_fifo.sv - warm-up filter and show-ahead output FIFO for median results
module median_out_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int WARMUP = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        median_in,
  input  logic                     in_en,
  input  logic                     clr_ovf,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0]    WARMUP_C = 8'(WARMUP);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        warm_cnt_q, warm_cnt_d;
  logic              ovf_q, ovf_d;

  logic warm_done;
  logic push_req;
  logic push;
  logic pop;
  logic drop;

  // Flags come straight from the registered occupancy.
  assign out_valid = (count_q != '0);
  assign full      = (count_q == DEPTH_C);
  assign count     = count_q;
  assign overflow  = ovf_q;
  // Show-ahead head; forced to zero while empty so reset shows a clean bus.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  // Handshake decode: a pop frees the slot a same-cycle push into a full FIFO needs.
  always_comb begin
    warm_done = (warm_cnt_q >= WARMUP_C);
    push_req  = in_en && warm_done;
    pop       = out_valid && out_ready;
    push      = push_req && (!full || pop);
    drop      = push_req && full && !pop;
  end

  // Next-state for pointers, occupancy, warm-up counter and sticky overflow.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    warm_cnt_d = (in_en && !warm_done) ? warm_cnt_q + 8'd1 : warm_cnt_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear keeps the flag set.
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      warm_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      warm_cnt_q <= warm_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Sample storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= median_in;
  end

endmodule
